// File: rtl/regfile_bypass.sv
// regfile_bypass: 32x64 ARMv8 register file with X31 zero, two mux-tree read ports and write-through bypass
module mux8 #(parameter int W = 64) (
  input  logic [2:0]     sel,
  input  logic [8*W-1:0] in,
  output logic [W-1:0]   out
);
  assign out = in[sel*W +: W];
endmodule

module mux4 #(parameter int W = 64) (
  input  logic [1:0]     sel,
  input  logic [4*W-1:0] in,
  output logic [W-1:0]   out
);
  assign out = in[sel*W +: W];
endmodule

module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);
  logic [WIDTH-1:0]          regs [NUM_REGS-1];
  logic [NUM_REGS*WIDTH-1:0] flat;
  logic [4:0]                raddr [2];
  logic [WIDTH-1:0]          rdata [2];
  logic                      write_en, bypass_en;
  assign write_en  = RegWrite && WriteRegister != 5'd31;
  assign bypass_en = write_en && !reset;
  assign raddr[0]  = ReadRegister1;
  assign raddr[1]  = ReadRegister2;
  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];
  // Storage: X0..X30 cleared asynchronously, written from WB on the rising edge
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    else if (write_en)
      regs[WriteRegister] <= WriteData;
  genvar r, p, g;
  for (r = 0; r < NUM_REGS; r++) begin : g_flat
    if (r == NUM_REGS - 1) begin : g_zero
      assign flat[r*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      assign flat[r*WIDTH +: WIDTH] = regs[r];
    end
  end
  for (p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] bank [4];
    logic [WIDTH-1:0] stored;
    for (g = 0; g < 4; g++) begin : g_bank
      mux8 #(.W(WIDTH)) u_mux8 (
        .sel (raddr[p][2:0]),
        .in  (flat[g*8*WIDTH +: 8*WIDTH]),
        .out (bank[g])
      );
    end
    mux4 #(.W(WIDTH)) u_mux4 (
      .sel (raddr[p][4:3]),
      .in  ({bank[3], bank[2], bank[1], bank[0]}),
      .out (stored)
    );
    assign rdata[p] = (reset || raddr[p] == 5'd31) ? '0 :
                      (bypass_en && WriteRegister == raddr[p]) ? WriteData : stored;
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed checks of reset, write/read, X31, bypass and full sweep
module tb_regfile_bypass;
  logic        clk = 0, reset = 1, RegWrite = 0;
  logic [4:0]  WriteRegister = 0, ReadRegister1 = 0, ReadRegister2 = 0;
  logic [63:0] WriteData = 0, ReadData1, ReadData2;
  int tests = 0, fails = 0;
  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  regfile_bypass dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    RegWrite = 1; WriteRegister = a; WriteData = d;
    tick;
    RegWrite = 0;
  endtask

  initial begin
    #2;
    check("rst_rd1", ReadData1, 0);
    check("rst_rd2", ReadData2, 0);
    RegWrite = 1; WriteRegister = 4; WriteData = 64'h5; ReadRegister1 = 4;
    #1 check("rst_no_bypass", ReadData1, 0);
    tick;
    reset = 0; RegWrite = 0;
    #1 check("rst_write_lost", ReadData1, 0);

    wr(5, 64'h1111_2222_3333_4444);
    ReadRegister1 = 5;
    #1 check("x5_written", ReadData1, 64'h1111_2222_3333_4444);
    reset = 1;
    #1 check("x5_during_rst", ReadData1, 0);
    reset = 0;
    #1 check("x5_cleared_async", ReadData1, 0);

    wr(7, 64'hDEAD_BEEF_0000_0001);
    ReadRegister1 = 7; ReadRegister2 = 6;
    #1 check("x7_read", ReadData1, 64'hDEAD_BEEF_0000_0001);
    check("x6_zero", ReadData2, 0);

    RegWrite = 1; WriteRegister = 31; WriteData = '1; ReadRegister1 = 31; ReadRegister2 = 31;
    #1 check("x31_pre_rd1", ReadData1, 0);
    check("x31_pre_rd2", ReadData2, 0);
    tick;
    RegWrite = 0;
    #1 check("x31_post_rd1", ReadData1, 0);
    check("x31_post_rd2", ReadData2, 0);

    wr(3, 64'hA);
    RegWrite = 1; WriteRegister = 3; WriteData = 64'hB; ReadRegister1 = 3; ReadRegister2 = 3;
    #1 check("bypass_rd1", ReadData1, 64'hB);
    check("bypass_rd2", ReadData2, 64'hB);
    tick;
    RegWrite = 0;
    #1 check("bypass_post_rd1", ReadData1, 64'hB);
    check("bypass_post_rd2", ReadData2, 64'hB);

    wr(3, 64'hA);
    RegWrite = 0; WriteRegister = 3; WriteData = 64'hB; ReadRegister1 = 3; ReadRegister2 = 9;
    #1 check("gate_pre", ReadData1, 64'hA);
    RegWrite = 1; WriteRegister = 9; WriteData = 64'hC;
    #1 check("port2_only_bypass", ReadData2, 64'hC);
    check("port1_no_bypass", ReadData1, 64'hA);
    RegWrite = 0;
    tick;
    check("gate_post", ReadData1, 64'hA);

    for (int i = 0; i < 32; i++) wr(5'(i), 64'(i) * STEP);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_%0d", i), ReadData1, i == 31 ? 64'h0 : 64'(i) * STEP);
      check($sformatf("sweep_rd2_%0d", 31 - i), ReadData2, i == 0 ? 64'h0 : 64'(31 - i) * STEP);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
